mem_port_arbiter: RTL

//  Shares one single-port unified memory between the multicycle CPU's instruction-fetch

---
 rtl/cpu_mem_pkg.sv | 24 ++
 rtl/arb_starve_ctr.sv | 36 +++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu_mem_pkg
// Brief  : Shared encodings for the CPU unified-memory port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

  // Wide enough for MEM_LAT-1 over the full legal latency range 1..15
  localparam int c_lat_cnt_w = 4;

endpackage
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module : arb_starve_ctr
// Brief  : Saturating counter of consecutive data grants taken while a fetch waits.
// Rev    : 1.0  initial release
// ============================================================================
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int c_cnt_w = $clog2(MAX + 1);
  localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(MAX);

  logic [c_cnt_w-1:0] r_cnt;

  // Clear wins over increment so a fetch grant always restarts the window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != c_max)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign at_max = (r_cnt == c_max);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Single-port memory arbiter between instruction fetch and data access.
// Rev    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [c_lat_cnt_w-1:0] c_lat_load = c_lat_cnt_w'(MEM_LAT - 1);
  localparam logic [c_lat_cnt_w-1:0] c_lat_one  = c_lat_cnt_w'(1);

  arb_state_t              r_state, w_state_nxt;
  arb_owner_t              r_owner, w_owner_nxt;
  logic [c_lat_cnt_w-1:0]  r_wait_cnt, w_cnt_nxt;
  logic                    r_if_gnt, r_dm_gnt, r_if_rvalid, r_dm_rvalid;
  logic                    r_mem_en, r_mem_we;
  logic [ADDR_W-1:0]       r_mem_addr, w_addr_nxt;
  logic [DATA_W-1:0]       r_mem_wdata, w_wdata_nxt;
  logic                    w_if_gnt_nxt, w_dm_gnt_nxt, w_rv_nxt;
  logic                    w_en_nxt, w_we_nxt;
  logic                    w_st_inc, w_st_clr, w_starve_max, w_dm_win;

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (w_st_inc),
    .clr    (w_st_clr),
    .at_max (w_starve_max)
  );

  // Data wins unless a waiting fetch has already been passed over STARVE_MAX times
  assign w_dm_win = dm_req && !(if_req && w_starve_max);

  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_cnt_nxt    = r_wait_cnt;
    w_addr_nxt   = r_mem_addr;
    w_wdata_nxt  = r_mem_wdata;
    w_en_nxt     = 1'b0;
    w_we_nxt     = 1'b0;
    w_if_gnt_nxt = 1'b0;
    w_dm_gnt_nxt = 1'b0;
    w_rv_nxt     = 1'b0;
    w_st_inc     = 1'b0;
    w_st_clr     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_st_clr = !if_req;
        if (w_dm_win) begin
          w_state_nxt  = ST_ISSUE;
          w_owner_nxt  = OWN_DM;
          w_addr_nxt   = dm_addr;
          w_wdata_nxt  = dm_wdata;
          w_en_nxt     = 1'b1;
          w_we_nxt     = dm_we;
          w_dm_gnt_nxt = 1'b1;
          w_st_inc     = if_req;
        end else if (if_req) begin
          w_state_nxt  = ST_ISSUE;
          w_owner_nxt  = OWN_IF;
          w_addr_nxt   = if_addr;
          w_en_nxt     = 1'b1;
          w_if_gnt_nxt = 1'b1;
          w_st_clr     = 1'b1;
        end
      end
      ST_ISSUE: begin
        w_state_nxt = ST_WAIT;
        w_cnt_nxt   = c_lat_load;
        w_rv_nxt    = (MEM_LAT == 1);
      end
      ST_WAIT: begin
        // rvalid is registered one edge early so it lands in the cycle the count reads 0
        if (r_wait_cnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_wait_cnt - 1'b1;
          w_rv_nxt  = (r_wait_cnt == c_lat_one);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_wait_cnt  <= '0;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_wait_cnt  <= w_cnt_nxt;
      r_if_gnt    <= w_if_gnt_nxt;
      r_dm_gnt    <= w_dm_gnt_nxt;
      r_if_rvalid <= w_rv_nxt && (r_owner == OWN_IF);
      r_dm_rvalid <= w_rv_nxt && (r_owner == OWN_DM);
      r_mem_en    <= w_en_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  assign if_gnt    = r_if_gnt;
  assign dm_gnt    = r_dm_gnt;
  assign if_rvalid = r_if_rvalid;
  assign dm_rvalid = r_dm_rvalid;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
